inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_inst_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Instruction sequencer: replays a stored program to three processors, issuing one
// instruction at a time and waiting for the target to go busy and then idle again.
module inst_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          done_p0,
  input  logic          done_p1,
  input  logic          done_p2,
  output logic [1:0]    proc,
  output logic [1:0]    opcode,
  output logic [3:0]    tag,
  output logic [7:0]    data,
  output logic          inst_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued,
  output logic          finished,
  output logic [1:0]    err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ACK   = 3'd2,
    BUSY  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PROC    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [15:0]   store [DEPTH];
  state_t        state;
  state_t        state_next;
  logic [AW:0]   len;
  logic [AW:0]   len_in;
  logic [AW:0]   pc_cnt;
  logic [AW:0]   pc_inc;
  logic [AW:0]   issued_cnt;
  logic [TW-1:0] timer;
  logic [1:0]    err_q;
  logic [15:0]   word_held;
  logic [15:0]   cur_word;
  logic [15:0]   word_out;
  logic          all_idle;
  logic          target_done;
  logic          last;
  logic          accept;
  logic          skip;
  logic          complete;
  logic          expired;

  assign all_idle = done_p0 & done_p1 & done_p2;
  assign len_in   = (prog_len > CNT_DEPTH) ? CNT_DEPTH : prog_len;
  assign pc_inc   = pc_cnt + CNT_ONE;
  assign last     = (pc_inc == len);
  assign cur_word = store[pc_cnt[AW-1:0]];

  always_comb begin
    case (word_held[15:14])
      2'b00:   target_done = done_p0;
      2'b01:   target_done = done_p1;
      default: target_done = done_p2;
    endcase
  end

  // Store is writable only while no run is in flight; contents survive reset.
  always_ff @(posedge clock) begin
    if (load_en && (state == IDLE || state == FIN)) begin
      store[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    skip       = 1'b0;
    complete   = 1'b0;
    expired    = 1'b0;
    inst_valid = 1'b0;
    finished   = 1'b0;
    case (state)
      IDLE, FIN: begin
        finished = (state == FIN);
        if (start && all_idle) begin
          accept     = 1'b1;
          state_next = (len_in == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (cur_word[15:14] == 2'b11) begin
          skip       = 1'b1;
          state_next = last ? FIN : ISSUE;
        end else begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (!target_done) begin
          state_next = BUSY;
        end else if (timer == TMR_LAST) begin
          expired    = 1'b1;
          complete   = 1'b1;
          state_next = last ? FIN : ISSUE;
        end
      end
      BUSY: begin
        if (all_idle) begin
          complete   = 1'b1;
          state_next = last ? FIN : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping; err only ever moves away from ERR_NONE once per run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      len        <= '0;
      pc_cnt     <= '0;
      issued_cnt <= '0;
      timer      <= '0;
      err_q      <= ERR_NONE;
      word_held  <= '0;
    end else begin
      if (accept) begin
        len        <= len_in;
        pc_cnt     <= '0;
        issued_cnt <= '0;
        err_q      <= ERR_NONE;
      end
      if (state == ISSUE) begin
        word_held <= cur_word;
        timer     <= '0;
      end
      if (state == ACK && target_done && !expired) begin
        timer <= timer + TMR_ONE;
      end
      if (skip) begin
        pc_cnt <= pc_inc;
        if (err_q == ERR_NONE) begin
          err_q <= ERR_PROC;
        end
      end
      if (complete) begin
        pc_cnt     <= pc_inc;
        issued_cnt <= issued_cnt + CNT_ONE;
      end
      if (expired && err_q == ERR_NONE) begin
        err_q <= ERR_TIMEOUT;
      end
    end
  end

  assign word_out = (state == ISSUE) ? cur_word : word_held;
  assign proc     = word_out[15:14];
  assign opcode   = word_out[13:12];
  assign tag      = word_out[11:8];
  assign data     = word_out[7:0];
  assign pc       = pc_cnt[AW-1:0];
  assign issued   = issued_cnt;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a processor responder model plus a scoreboard of
// expected issued words, compared against every observed inst_valid pulse.
module tb_inst_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  prog_len;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        done_p0;
  logic        done_p1;
  logic        done_p2;
  logic [1:0]  proc;
  logic [1:0]  opcode;
  logic [3:0]  tag;
  logic [7:0]  data;
  logic        inst_valid;
  logic [3:0]  pc;
  logic [4:0]  issued;
  logic        finished;
  logic [1:0]  err;

  logic [2:0]  resp_low = 3'b000;
  logic [2:0]  force_low;
  logic        resp_on;

  logic [19:0] exp_q[$];
  logic [19:0] obs_word [128];
  int          obs_cyc [128];
  int          pulse_cnt = 0;
  int          rd_idx;
  int          cyc = 0;
  int          errors;
  int          checks;
  int          base;

  assign done_p0 = !(resp_low[0] | force_low[0]);
  assign done_p1 = !(resp_low[1] | force_low[1]);
  assign done_p2 = !(resp_low[2] | force_low[2]);

  inst_sequencer #(.DEPTH(16), .TIMEOUT(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .done_p0    (done_p0),
    .done_p1    (done_p1),
    .done_p2    (done_p2),
    .proc       (proc),
    .opcode     (opcode),
    .tag        (tag),
    .data       (data),
    .inst_valid (inst_valid),
    .pc         (pc),
    .issued     (issued),
    .finished   (finished),
    .err        (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  // Monitor: record every issue strobe with its pc and fields.
  initial begin
    forever begin
      @(negedge clock);
      if (inst_valid === 1'b1) begin
        if (pulse_cnt < 128) begin
          obs_word[pulse_cnt] = {pc, proc, opcode, tag, data};
          obs_cyc[pulse_cnt]  = cyc;
        end
        pulse_cnt = pulse_cnt + 1;
      end
    end
  end

  // Processor model: target goes busy one cycle after the strobe, idle four cycles later.
  initial begin
    logic [1:0] tgt;
    forever begin
      @(negedge clock);
      if (inst_valid === 1'b1 && resp_on && proc != 2'b11) begin
        tgt = proc;
        @(posedge clock);
        #1 resp_low[tgt] = 1'b1;
        repeat (4) @(posedge clock);
        #1 resp_low[tgt] = 1'b0;
      end
    end
  end

  task automatic check(string name, logic [31:0] observed, logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(logic [3:0] addr, logic [15:0] word);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = word;
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic run(logic [4:0] len);
    start    = 1'b1;
    prog_len = len;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic push(int idx, logic [15:0] word);
    exp_q.push_back({4'(idx), word});
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic wait_fin(string name, int max);
    int n = 0;
    while (finished !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
    check({name, "_fin"}, 32'(finished), 32'd1);
  endtask

  task automatic drain(string name);
    logic [19:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < pulse_cnt) begin
        check({name, "_issue"}, 32'(obs_word[rd_idx]), 32'(e));
        rd_idx++;
      end else begin
        check({name, "_missing"}, 32'(pulse_cnt), 32'(rd_idx + 1));
      end
    end
    check({name, "_pulses"}, 32'(pulse_cnt), 32'(rd_idx));
    rd_idx = pulse_cnt;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rd_idx    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    prog_len  = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    force_low = 3'b000;
    resp_on   = 1'b1;
    tick(3);
    reset = 1'b1;
    check("rst_fields", 32'({proc, opcode, tag, data}), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_fin", 32'(finished), 32'd0);
    check("rst_pc_issued_err", 32'({pc, issued, err}), 32'h0);

    // Two-instruction run with normal handshakes.
    load(4'd0, 16'h1A05);
    load(4'd1, 16'h5B22);
    push(0, 16'h1A05);
    push(1, 16'h5B22);
    base = pulse_cnt;
    run(5'd2);
    wait_fin("basic", 100);
    check("basic_issued", 32'(issued), 32'd2);
    check("basic_err", 32'(err), 32'd0);
    check("basic_pc", 32'(pc), 32'd2);
    check("basic_gap", 32'(obs_cyc[base + 1] - obs_cyc[base]), 32'd6);
    check("basic_hold", 32'({proc, opcode, tag, data}), 32'h5B22);
    drain("basic");

    // Bad processor field is skipped.
    load(4'd0, 16'hC000);
    push(0, 16'hC000);
    run(5'd1);
    wait_fin("badproc", 20);
    check("badproc_err", 32'(err), 32'd1);
    check("badproc_issued", 32'(issued), 32'd0);
    check("badproc_pc", 32'(pc), 32'd1);
    drain("badproc");

    // Timeout on the first instruction, then a bad one, then a normal one.
    load(4'd0, 16'h0177);
    load(4'd1, 16'hC0FF);
    load(4'd2, 16'h9C33);
    push(0, 16'h0177);
    push(1, 16'hC0FF);
    push(2, 16'h9C33);
    resp_on = 1'b0;
    run(5'd3);
    check("tmo_err_cleared", 32'(err), 32'd0);
    tick(32);
    check("tmo_before_err", 32'(err), 32'd0);
    check("tmo_before_issued", 32'(issued), 32'd0);
    resp_on = 1'b1;
    tick(1);
    check("tmo_err", 32'(err), 32'd2);
    check("tmo_issued", 32'(issued), 32'd1);
    check("tmo_next_issue", 32'({inst_valid, pc}), 32'h11);
    wait_fin("tmo", 100);
    check("tmo_sticky_err", 32'(err), 32'd2);
    check("tmo_final_issued", 32'(issued), 32'd2);
    check("tmo_final_pc", 32'(pc), 32'd3);
    drain("tmo");

    // Reset in the BUSY phase of the second of four instructions.
    load(4'd0, 16'h0111);
    load(4'd1, 16'h4222);
    load(4'd2, 16'h8333);
    load(4'd3, 16'h0444);
    push(0, 16'h0111);
    push(1, 16'h4222);
    run(5'd4);
    tick(8);
    check("midrun_issued", 32'(issued), 32'd1);
    check("midrun_pc", 32'(pc), 32'd1);
    check("midrun_err", 32'(err), 32'd0);
    check("midrun_valid", 32'(inst_valid), 32'd0);
    pulse_reset();
    check("mrst_fields", 32'({proc, opcode, tag, data}), 32'h0);
    check("mrst_pc_issued_err", 32'({pc, issued, err}), 32'h0);
    check("mrst_flags", 32'({inst_valid, finished}), 32'h0);
    tick(4);
    check("mrst_idle", 32'({inst_valid, finished}), 32'h0);
    drain("mrst");
    push(0, 16'h0111);
    push(1, 16'h4222);
    run(5'd2);
    wait_fin("rerun", 100);
    check("rerun_issued", 32'(issued), 32'd2);
    drain("rerun");

    // start blocked by a busy processor, then a zero-length program.
    pulse_reset();
    force_low = 3'b010;
    start     = 1'b1;
    prog_len  = 5'd1;
    tick(5);
    check("blocked_fin", 32'(finished), 32'd0);
    start     = 1'b0;
    force_low = 3'b000;
    tick(1);
    drain("blocked");
    run(5'd0);
    check("len0_fin", 32'(finished), 32'd1);
    check("len0_issued", 32'(issued), 32'd0);
    tick(3);
    drain("len0");

    // Store writes while a run is active are ignored.
    push(0, 16'h0111);
    run(5'd1);
    tick(1);
    check("ackload_state", 32'(inst_valid), 32'd0);
    load(4'd0, 16'hFFFF);
    wait_fin("ackload", 50);
    push(0, 16'h0111);
    run(5'd1);
    wait_fin("ackload_rerun", 50);
    drain("ackload");

    // Load and start in the same IDLE cycle.
    pulse_reset();
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = 16'h3ABC;
    push(0, 16'h3ABC);
    run(5'd1);
    load_en = 1'b0;
    check("sameclk_fields", 32'({inst_valid, proc, opcode, tag, data}), 32'h13ABC);
    wait_fin("sameclk", 50);
    drain("sameclk");

    // Oversized length clamps to the full store.
    for (int i = 0; i < 16; i++) begin
      load(4'(i), {2'(i % 3), 2'b01, 4'(i), 8'(i * 7)});
      push(i, {2'(i % 3), 2'b01, 4'(i), 8'(i * 7)});
    end
    run(5'd20);
    wait_fin("clamp", 400);
    check("clamp_issued", 32'(issued), 32'd16);
    check("clamp_err", 32'(err), 32'd0);
    drain("clamp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
